// File: rtl/bubble_host_sequencer_if.sv
// Host-side strobe/data bundle between the bubble host sequencer and its user.
// The slave modport is the sequencer; master is whoever starts runs and feeds drive data.
interface bubble_host_sequencer_if;
    logic       START_BOOT;
    logic       START_PAGE;
    logic       DOUT0;
    logic       DOUT1;
    logic       nBSEN;
    logic       nREPEN;
    logic       nBOOTEN;
    logic       BUSY;
    logic [7:0] BYTE0;
    logic [7:0] BYTE1;
    logic       BYTE_VALID;
    logic       BOOT_DONE;

    modport slave (
        input  START_BOOT, START_PAGE, DOUT0, DOUT1,
        output nBSEN, nREPEN, nBOOTEN, BUSY, BYTE0, BYTE1, BYTE_VALID, BOOT_DONE
    );

    modport master (
        output START_BOOT, START_PAGE, DOUT0, DOUT1,
        input  nBSEN, nREPEN, nBOOTEN, BUSY, BYTE0, BYTE1, BYTE_VALID, BOOT_DONE
    );
endinterface

// File: rtl/bubble_host_sequencer.sv
// Host-side exerciser for the BubbleDrive8: generates nBSEN/nREPEN/nBOOTEN for boot-loop
// or single-page reads and deserialises DOUT0/DOUT1 into byte pairs.
module bubble_host_sequencer #(
    parameter int unsigned LEAD_CYC     = 38,
    parameter int unsigned REP_LOW_CYC  = 687,
    parameter int unsigned REP_HIGH_CYC = 1233,
    parameter int unsigned BOOT_REPS    = 64,
    parameter int unsigned BIT_CYC      = 32,
    parameter int unsigned PAGE_BITS    = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                     MCLK,
    input  logic                     nRESET,
    bubble_host_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_CYC - 1);
    localparam logic [CNT_W-1:0] RL_LAST   = CNT_W'(REP_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RH_LAST   = CNT_W'(REP_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] REPS_LAST = CNT_W'(BOOT_REPS - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] PAGE_LAST = CNT_W'(PAGE_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_REP_LO = 3'd2,
        S_REP_HI = 3'd3,
        S_SHIFT  = 3'd4,
        S_END    = 3'd5
    } state_t;

    state_t           state;
    logic             boot_mode;
    logic [CNT_W-1:0] cnt;       // cycles within the current phase / bit period
    logic [CNT_W-1:0] rep_cnt;   // replicate pulses (boot) or page bits (page)
    logic [CNT_W-1:0] tick_cnt;  // sample tick phase
    logic [2:0]       bit_cnt;
    logic [7:0]       sr0;
    logic [7:0]       sr1;
    logic [1:0]       sync0;
    logic [1:0]       sync1;
    logic             tick_c;
    logic             start_c;

    // Sample tick: once at LEAD exit, then every BIT_CYC cycles while the drive is shifting.
    always_comb begin
        tick_c = 1'b0;
        if (state == S_LEAD) begin
            tick_c = (cnt == LEAD_LAST);
        end else if (state inside {S_REP_LO, S_REP_HI, S_SHIFT}) begin
            tick_c = (tick_cnt == BIT_LAST);
        end
    end

    assign start_c = bus.START_BOOT | bus.START_PAGE;

    // Two-flop synchronisers for the drive data streams.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            sync0 <= 2'b00;
            sync1 <= 2'b00;
        end else begin
            sync0 <= {sync0[0], bus.DOUT0};
            sync1 <= {sync1[0], bus.DOUT1};
        end
    end

    // Deserialiser: MSB-first shift, byte pair published on every 8th tick.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            tick_cnt       <= '0;
            bit_cnt        <= 3'd0;
            sr0            <= 8'h00;
            sr1            <= 8'h00;
            bus.BYTE0      <= 8'h00;
            bus.BYTE1      <= 8'h00;
            bus.BYTE_VALID <= 1'b0;
        end else begin
            bus.BYTE_VALID <= 1'b0;

            if (state == S_LEAD) begin
                tick_cnt <= '0;
            end else if (state inside {S_REP_LO, S_REP_HI, S_SHIFT}) begin
                tick_cnt <= tick_c ? '0 : tick_cnt + CNT_ONE;
            end

            if (state == S_IDLE && start_c) begin
                bit_cnt <= 3'd0;
            end else if (tick_c) begin
                sr0     <= {sr0[6:0], sync0[1]};
                sr1     <= {sr1[6:0], sync1[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    bus.BYTE0      <= {sr0[6:0], sync0[1]};
                    bus.BYTE1      <= {sr1[6:0], sync1[1]};
                    bus.BYTE_VALID <= 1'b1;
                end
            end
        end
    end

    // Run sequencer with registered strobes.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state         <= S_IDLE;
            boot_mode     <= 1'b0;
            cnt           <= '0;
            rep_cnt       <= '0;
            bus.nBSEN     <= 1'b1;
            bus.nREPEN    <= 1'b1;
            bus.nBOOTEN   <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.BOOT_DONE <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        boot_mode <= bus.START_BOOT;
                        bus.nBSEN <= 1'b0;
                        bus.BUSY  <= 1'b1;
                        if (bus.START_BOOT) begin
                            bus.nBOOTEN <= 1'b0;
                        end
                        cnt     <= '0;
                        rep_cnt <= '0;
                        state   <= S_LEAD;
                    end
                end

                S_LEAD: begin
                    if (cnt == LEAD_LAST) begin
                        cnt        <= '0;
                        bus.nREPEN <= 1'b0;
                        state      <= S_REP_LO;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_REP_LO: begin
                    if (cnt == RL_LAST) begin
                        cnt        <= '0;
                        bus.nREPEN <= 1'b1;
                        if (boot_mode) begin
                            if (rep_cnt == REPS_LAST) begin
                                state <= S_END;
                            end else begin
                                rep_cnt <= rep_cnt + CNT_ONE;
                                state   <= S_REP_HI;
                            end
                        end else begin
                            rep_cnt <= '0;
                            state   <= S_SHIFT;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_REP_HI: begin
                    if (cnt == RH_LAST) begin
                        cnt        <= '0;
                        bus.nREPEN <= 1'b0;
                        state      <= S_REP_LO;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Page body lasts PAGE_BITS whole bit periods.
                S_SHIFT: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rep_cnt == PAGE_LAST) begin
                            state <= S_END;
                        end else begin
                            rep_cnt <= rep_cnt + CNT_ONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_END: begin
                    bus.nBSEN <= 1'b1;
                    bus.BUSY  <= 1'b0;
                    if (boot_mode) begin
                        bus.nBOOTEN   <= 1'b1;
                        bus.BOOT_DONE <= 1'b1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
